// File: rtl/fwd_scoreboard_mux.sv
// Forwarding and load-use hazard unit: tracks in-flight destination tags and
// resolves each ID source operand to the youngest producer or the register file.
module fwd_scoreboard_mux #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int STAGES     = 3,
  parameter int LOAD_READY = 1,
  parameter int SEL_W      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        issue_valid,
  input  logic [REG_AW-1:0]           issue_dst,
  input  logic                        issue_wen,
  input  logic                        issue_load,
  input  logic                        flush,
  input  logic [NUM_SRC*REG_AW-1:0]   src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]   rf_data,
  input  logic [STAGES*DATA_W-1:0]    stage_data,
  output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
  output logic                        stall,
  output logic [15:0]                 stall_cnt
);

  if (STAGES < 1) begin : g_bad_stages
    $error("STAGES must be at least 1");
  end
  if (SEL_W < $clog2(STAGES + 1)) begin : g_bad_sel
    $error("SEL_W too narrow for STAGES+1 select codes");
  end
  if (LOAD_READY > STAGES - 1) begin : g_bad_ready
    $error("LOAD_READY must be <= STAGES-1");
  end

  // Handshake: the ID instruction moves into EX on an edge where
  // issue_valid=1, stall=0 and flush=0; on any other edge a bubble enters EX.
  logic                     take;
  logic [STAGES-1:0]        valid_q, valid_d;
  logic [STAGES-1:0]        wen_q, wen_d;
  logic [STAGES-1:0]        load_q, load_d;
  logic [STAGES*REG_AW-1:0] dst_q, dst_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [NUM_SRC-1:0]       not_ready;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    fwd_data  = '0;
    fwd_sel   = '0;
    not_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_data[i*DATA_W +: DATA_W] = rf_data[i*DATA_W +: DATA_W];
      for (int k = STAGES - 1; k >= 0; k--) begin
        if (valid_q[k] && wen_q[k] &&
            (dst_q[k*REG_AW +: REG_AW] == src_addr[i*REG_AW +: REG_AW]) &&
            (src_addr[i*REG_AW +: REG_AW] != '0)) begin
          fwd_sel[i*SEL_W +: SEL_W]    = SEL_W'(k + 1);
          fwd_data[i*DATA_W +: DATA_W] = stage_data[k*DATA_W +: DATA_W];
          not_ready[i]                 = load_q[k] && (k < LOAD_READY);
        end
      end
    end
  end

  assign stall = issue_valid & (|not_ready);
  assign take  = issue_valid & ~stall & ~flush;

  always_comb begin
    valid_d = valid_q;
    wen_d   = wen_q;
    load_d  = load_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    valid_d[0]          = take;
    wen_d[0]            = take & issue_wen;
    load_d[0]           = take & issue_load;
    dst_d[0 +: REG_AW]  = issue_dst;
    // Older entries always advance; a stall only affects what enters entry 0.
    for (int k = 1; k < STAGES; k++) begin
      valid_d[k]                 = valid_q[k-1];
      wen_d[k]                   = wen_q[k-1];
      load_d[k]                  = load_q[k-1];
      dst_d[k*REG_AW +: REG_AW]  = dst_q[(k-1)*REG_AW +: REG_AW];
    end
    if (stall && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      wen_q   <= '0;
      load_q  <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wen_q   <= wen_d;
      load_q  <= load_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard_mux.sv
// Directed and randomized checks of fwd_scoreboard_mux against a queue-based
// model of the in-flight instructions.
module tb_fwd_scoreboard_mux;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int ST = 3;
  localparam int LR = 1;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic issue_valid, issue_wen, issue_load, flush;
  logic [AW-1:0] issue_dst;
  logic [AW-1:0] src_a [NS];
  logic [DW-1:0] rf_a [NS];
  logic [DW-1:0] sd [ST];
  logic [NS*AW-1:0] src_addr;
  logic [NS*DW-1:0] rf_data;
  logic [ST*DW-1:0] stage_data;
  logic [NS*DW-1:0] fwd_data;
  logic [NS*SW-1:0] fwd_sel;
  logic stall;
  logic [15:0] stall_cnt;

  for (genvar g = 0; g < NS; g++) begin : g_pack_src
    assign src_addr[g*AW +: AW] = src_a[g];
    assign rf_data[g*DW +: DW]  = rf_a[g];
  end
  for (genvar g = 0; g < ST; g++) begin : g_pack_stage
    assign stage_data[g*DW +: DW] = sd[g];
  end

  fwd_scoreboard_mux #(
    .DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .STAGES(ST), .LOAD_READY(LR), .SEL_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_dst(issue_dst),
    .issue_wen(issue_wen), .issue_load(issue_load), .flush(flush),
    .src_addr(src_addr), .rf_data(rf_data), .stage_data(stage_data),
    .fwd_data(fwd_data), .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: pipe[0] is the instruction in EX, pipe[ST-1] the one in WB.
  typedef struct { bit v; bit [AW-1:0] dst; bit wen; bit ld; } ent_t;
  ent_t pipe[$];
  int unsigned cnt_m;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    ent_t b;
    b = '{v: 1'b0, dst: '0, wen: 1'b0, ld: 1'b0};
    pipe.delete();
    for (int k = 0; k < ST; k++) pipe.push_back(b);
    cnt_m = 0;
  endfunction

  function automatic void resolve(input int i, output logic [SW-1:0] es,
                                  output logic [DW-1:0] ed, output bit nr);
    es = '0;
    ed = rf_a[i];
    nr = 1'b0;
    if (src_a[i] != 0) begin
      for (int k = 0; k < ST; k++) begin
        if (pipe[k].v && pipe[k].wen && pipe[k].dst == src_a[i]) begin
          es = SW'(k + 1);
          ed = sd[k];
          nr = pipe[k].ld && (k < LR);
          break;
        end
      end
    end
  endfunction

  function automatic bit model_stall();
    logic [SW-1:0] es;
    logic [DW-1:0] ed;
    bit nr;
    bit any = 1'b0;
    for (int i = 0; i < NS; i++) begin
      resolve(i, es, ed, nr);
      any |= nr;
    end
    return issue_valid && any;
  endfunction

  task automatic check_comb(input string tag);
    logic [SW-1:0] es;
    logic [DW-1:0] ed;
    bit nr;
    for (int i = 0; i < NS; i++) begin
      resolve(i, es, ed, nr);
      chk($sformatf("%s.sel%0d", tag, i), 32'(fwd_sel[i*SW +: SW]), 32'(es));
      chk($sformatf("%s.data%0d", tag, i), fwd_data[i*DW +: DW], ed);
    end
    chk({tag, ".stall"}, 32'(stall), 32'(model_stall()));
    chk({tag, ".cnt"}, 32'(stall_cnt), cnt_m);
  endtask

  task automatic tick();
    bit s;
    ent_t e;
    s = model_stall();
    e = '{v: 1'b0, dst: '0, wen: 1'b0, ld: 1'b0};
    if (issue_valid && !s && !flush)
      e = '{v: 1'b1, dst: issue_dst, wen: issue_wen, ld: issue_load};
    @(posedge clk);
    pipe.push_front(e);
    void'(pipe.pop_back());
    if (s && cnt_m < 32'hFFFF) cnt_m++;
    #1;
  endtask

  task automatic cyc(input string tag);
    #2;
    check_comb(tag);
    tick();
  endtask

  task automatic drive_issue(input bit v, input logic [AW-1:0] d, input bit w,
                             input bit l, input bit f);
    issue_valid = v;
    issue_dst   = d;
    issue_wen   = w;
    issue_load  = l;
    flush       = f;
  endtask

  task automatic idle();
    drive_issue(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NS; i++) begin
      src_a[i] = '0;
      rf_a[i]  = DW'($urandom);
    end
    for (int k = 0; k < ST; k++) sd[k] = DW'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset with a load sitting in EX.
    drive_issue(1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
    cyc("rst_pre");
    drive_issue(1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
    src_a[0] = 5'd7;
    #2;
    chk("rst_stall_before", 32'(stall), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_sel", 32'(fwd_sel), 32'd0);
    chk("rst_data0", fwd_data[0 +: DW], rf_a[0]);
    chk("rst_data1", fwd_data[DW +: DW], rf_a[1]);
    model_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_cnt", 32'(stall_cnt), 32'd0);

    // Load-use: one stall cycle, then forward from MEM.
    drive_issue(1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
    cyc("lu_iss");
    drive_issue(1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
    src_a[0] = 5'd7;
    sd[1] = 32'h0000_0077;
    #2;
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_sel_ex", 32'(fwd_sel[0 +: SW]), 32'd1);
    chk("lu_cnt0", 32'(stall_cnt), 32'd0);
    tick();
    chk("lu_cnt1", 32'(stall_cnt), 32'd1);
    #2;
    chk("lu_stall_clr", 32'(stall), 32'd0);
    chk("lu_sel_mem", 32'(fwd_sel[0 +: SW]), 32'd2);
    chk("lu_data_mem", fwd_data[0 +: DW], 32'h0000_0077);
    tick();

    // EX forward.
    idle();
    drive_issue(1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    cyc("ex_iss");
    idle();
    src_a[0] = 5'd3;
    sd[0] = 32'h0000_1234;
    #2;
    chk("ex_sel", 32'(fwd_sel[0 +: SW]), 32'd1);
    chk("ex_data", fwd_data[0 +: DW], 32'h0000_1234);
    chk("ex_stall", 32'(stall), 32'd0);
    tick();

    // Youngest producer wins.
    drive_issue(1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc("yw_iss1");
    cyc("yw_iss2");
    idle();
    src_a[0] = 5'd5;
    sd[0] = 32'h0000_AAAA;
    sd[1] = 32'h0000_BBBB;
    #2;
    chk("yw_sel", 32'(fwd_sel[0 +: SW]), 32'd1);
    chk("yw_data", fwd_data[0 +: DW], 32'h0000_AAAA);
    tick();

    // Register 0 never forwards.
    drive_issue(1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("r0_iss");
    idle();
    rf_a[0] = 32'h0000_CAFE;
    #2;
    chk("r0_sel", 32'(fwd_sel[0 +: SW]), 32'd0);
    chk("r0_data", fwd_data[0 +: DW], 32'h0000_CAFE);
    tick();

    // Flushed load leaves no producer.
    drive_issue(1'b1, 5'd8, 1'b1, 1'b1, 1'b1);
    cyc("fl_iss");
    drive_issue(1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
    src_a[0] = 5'd8;
    #2;
    chk("fl_stall", 32'(stall), 32'd0);
    chk("fl_sel", 32'(fwd_sel[0 +: SW]), 32'd0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive_issue(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)),
                  1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 9) < 3),
                  1'($urandom_range(0, 9) == 0));
      for (int i = 0; i < NS; i++) begin
        src_a[i] = AW'($urandom_range(0, 7));
        rf_a[i]  = DW'($urandom);
      end
      for (int k = 0; k < ST; k++) sd[k] = DW'($urandom);
      cyc("rnd");
    end

    // Saturation: hold a load in EX for long enough to overflow 16 bits.
    idle();
    drive_issue(1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
    src_a[0] = 5'd9;
    force dut.valid_q = '1;
    force dut.wen_q   = '1;
    force dut.load_q  = '1;
    force dut.dst_q   = {ST{5'd9}};
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_stall", 32'(stall), 32'd1);
    chk("sat_cnt", 32'(stall_cnt), 32'h0000_FFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
    release dut.valid_q;
    release dut.wen_q;
    release dut.load_q;
    release dut.dst_q;
    idle();
    rst_n = 1'b0;
    #2;
    chk("sat_rst_cnt", 32'(stall_cnt), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fwd_scoreboard_mux.md
Name: fwd_scoreboard_mux

Overview:
- Parametrised forwarding and hazard unit for the pipelined CPU.
- Tracks destination tags of in-flight instructions in a STAGES-deep shift register.
- For each of NUM_SRC source operands in ID, picks the youngest matching producer's data or falls back to register-file data.
- Raises a load-use stall when the matching producer's data is not ready, and keeps a saturating stall counter. It replaces the fixed 2-source, 3-way forwarding muxes.

Parameters:
DATA_W, 32, operand/data width
REG_AW, 5, register address width
NUM_SRC, 2, number of source operands resolved per cycle
STAGES, 3, tracked producer stages after ID (0=EX, 1=MEM, 2=WB)
LOAD_READY, 1, first stage index at which load data is valid in stage_data
SEL_W, 2, width of each select code; must hold STAGES+1 values

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  ID holds a valid instruction attempting to advance to EX
issue_dst  in  REG_AW  destination register of issuing instruction
issue_wen  in  1  issuing instruction writes a register
issue_load  in  1  issuing instruction is a load
flush  in  1  squash the issuing instruction at this edge
src_addr  in  NUM_SRC*REG_AW  source register addresses; operand i at [i*REG_AW +: REG_AW]
rf_data  in  NUM_SRC*DATA_W  register-file read data per operand
stage_data  in  STAGES*DATA_W  result data of the instruction in stage k, at [k*DATA_W +: DATA_W]
fwd_data  out  NUM_SRC*DATA_W  resolved operand data
fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, k+1 = stage k
stall  out  1  hold PC and IF/ID; bubble into EX
stall_cnt  out  16  count of stalled cycles, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): all tracker entries invalid; stall_cnt=0.
  - Consequently stall=0, fwd_sel=0 and fwd_data=rf_data.
- Tracker entry k holds {valid, dst, wen, load}. On every clk edge: entry k+1 <= entry k for k=0..STAGES-2, and entry STAGES-1 is discarded.
- Entry 0 is loaded as follows:
  - issue_valid & ~stall & ~flush: loaded with the issue fields.
  - Otherwise: loaded with a bubble (valid=0).
  - Older entries always shift; stall never freezes them.
- Match rule for operand i: entry k matches when valid & wen & dst==src_addr[i] & src_addr[i]!=0.
  - Register 0 never matches and always reads rf_data (value from the register file).
- Priority: the lowest k (youngest) match wins.
- Selection is combinational, same cycle as src_addr:
  - Winning entry k: fwd_sel=k+1, fwd_data=stage_data[k].
  - No match: fwd_sel=0, fwd_data=rf_data[i].
- Not ready: a winning entry is not ready when load=1 and k<LOAD_READY.
- stall = issue_valid & OR over operands of (winning entry not ready). It is combinational.
  - A younger not-ready match shadows any older ready match. Stall is still raised and no bypass around it is allowed.
- While stall=1, fwd_sel/fwd_data still reflect the match; the consumer ignores them.
- The stall clears automatically once the load has shifted to k>=LOAD_READY, after LOAD_READY-k cycles of bubbles.
- flush & stall in the same cycle: a bubble is inserted; flush has no other effect.
- issue_valid=0: stall=0. Forwarding outputs are still computed.
- stall_cnt: increments by 1 on each edge where stall=1. It holds at 16'hFFFF and is cleared only by reset.
- Synthesis-time requirements:
  - SEL_W >= clog2(STAGES+1).
  - LOAD_READY <= STAGES-1.
  - STAGES >= 1.

Test Plan:
- Reset: rst_n=0 mid-stream with a load in entry 0. Expect entries cleared immediately, stall=0, fwd_sel=0 and fwd_data=rf_data without waiting for clk. After release, stall_cnt=0.
- EX forward: issue add r3 (wen=1), next cycle src_addr[0]=3, stage_data[0]=32'h0000_1234. Expect fwd_sel[0]=1, fwd_data[0]=32'h1234, stall=0.
- Youngest wins: issue r5 writers on two consecutive cycles, then read r5 with stage_data[0]=32'hAAAA, stage_data[1]=32'hBBBB. Expect fwd_sel=1, data 32'hAAAA.
- Load-use: issue lw r7, next cycle read r7 with issue_valid=1. Expect stall=1 for exactly 1 cycle and stall_cnt 0->1. The following cycle fwd_sel=2 with stage_data[1] and stall=0.
- r0 and flush:
  - Writer to r0 then read r0: expect fwd_sel=0.
  - Issue lw r8 with flush=1, then read r8: expect no stall and fwd_sel=0.
- Saturation: hold a stall condition for 70000 cycles by keeping issue_valid=1 and re-issuing the load each cycle via force. Expect stall_cnt=16'hFFFF and no wrap.
